// File: rtl/run_control_pkg.sv
// Shared global parameters for the CPU and its run-control block:
// run-state encoding, host command encoding and the default HALT opcode.
package run_control_pkg;

   typedef enum logic [1:0] {
      RS_RESET    = 2'b00,
      RS_HALTED   = 2'b01,
      RS_RUNNING  = 2'b10,
      RS_STEPPING = 2'b11
   } run_state_e;

   typedef enum logic [1:0] {
      CMD_HALT  = 2'b00,
      CMD_RUN   = 2'b01,
      CMD_STEP  = 2'b10,
      CMD_SETBP = 2'b11
   } cmd_code_e;

   // All-ones pattern, truncated to the opcode width at the point of use.
   localparam logic [31:0] HALT_OPCODE_ALL_ONES = '1;

endpackage

// File: rtl/run_control_if.sv
// Host command channel for run_control: valid/ready handshake carrying a
// 2-bit command code and an 8-bit argument (step count or breakpoint address).
interface run_control_if;

   logic       cmdValid;
   logic       cmdReady;
   logic [1:0] cmdCode;
   logic [7:0] cmdData;

   modport master (
      output cmdValid,
      output cmdCode,
      output cmdData,
      input  cmdReady
   );

   modport slave (
      input  cmdValid,
      input  cmdCode,
      input  cmdData,
      output cmdReady
   );

endinterface

// File: rtl/run_control_breakpoint_unit.sv
// Single hardware breakpoint: holds an address and a valid flag, and flags
// when the CPU presents the instruction at that address.
module breakpoint_unit #(
   parameter int PC_WIDTH = 8
) (
   input  logic                clock,
   input  logic                isResetN,
   input  logic                set_bp,
   input  logic [PC_WIDTH-1:0] set_addr,
   input  logic [PC_WIDTH-1:0] pc,
   output logic                bp_match
);

   logic                bp_valid_q, bp_valid_d;
   logic [PC_WIDTH-1:0] bp_addr_q,  bp_addr_d;

   // Load a new breakpoint address whenever the host sets one.
   always_comb begin
      bp_valid_d = bp_valid_q;
      bp_addr_d  = bp_addr_q;
      if (set_bp) begin
         bp_valid_d = 1'b1;
         bp_addr_d  = set_addr;
      end
   end

   // Breakpoint registers, cleared by the synchronous reset.
   always_ff @(posedge clock) begin
      if (!isResetN) begin
         bp_valid_q <= 1'b0;
         bp_addr_q  <= '0;
      end else begin
         bp_valid_q <= bp_valid_d;
         bp_addr_q  <= bp_addr_d;
      end
   end

   assign bp_match = bp_valid_q & (pc == bp_addr_q);

endmodule

// File: rtl/run_control.sv
// CPU run control: holds the CPU in reset after power-up, then lets a host
// halt, run and single-step it. Execution stops on the HALT opcode and, when
// RUN_CONTROL_BREAKPOINT_EN is defined, on a single address breakpoint.
// After a stop, the first instruction on resume is always executed (skip).
module run_control
   import run_control_pkg::*;
#(
   parameter int                      PC_WIDTH     = 8,
   parameter int                      OPCODE_WIDTH = 6,
   parameter int                      RESET_CYCLES = 4,
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = OPCODE_WIDTH'(HALT_OPCODE_ALL_ONES)
) (
   input  logic                    clock,
   input  logic                    isResetN,
   run_control_if.slave            cmd,
   input  logic [PC_WIDTH-1:0]     pc,
   input  logic [OPCODE_WIDTH-1:0] opCode,
   output logic                    cpuEnable,
   output logic                    cpuReset,
   output logic [1:0]              runState,
   output logic [7:0]              stepsLeft,
   output logic                    bpHit
);

   localparam int              CNT_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

   run_state_e       state_q,      state_d;
   logic [CNT_W-1:0] rst_cnt_q,    rst_cnt_d;
   logic [7:0]       steps_left_q, steps_left_d;
   logic             skip_q,       skip_d;

   cmd_code_e cmd_code;
   logic      cmd_fire;
   logic      cmd_run, cmd_step, cmd_halt;
   logic      active;
   logic      bp_term;
   logic      stop_now;
   logic      cpu_en;

   assign cmd_code = cmd_code_e'(cmd.cmdCode);
   assign cmd_fire = cmd.cmdValid & cmd.cmdReady;
   assign cmd_run  = cmd_fire & (cmd_code == CMD_RUN);
   assign cmd_step = cmd_fire & (cmd_code == CMD_STEP);
   assign cmd_halt = cmd_fire & (cmd_code == CMD_HALT);

   assign active   = (state_q == RS_RUNNING) | (state_q == RS_STEPPING);
   assign stop_now = (bp_term | (opCode == HALT_OPCODE)) & ~skip_q;
   assign cpu_en   = active & ~stop_now;

`ifdef RUN_CONTROL_BREAKPOINT_EN
   logic bp_hit_q, bp_hit_d;

   breakpoint_unit #(
      .PC_WIDTH (PC_WIDTH)
   ) u_breakpoint_unit (
      .clock    (clock),
      .isResetN (isResetN),
      .set_bp   (cmd_fire & (cmd_code == CMD_SETBP)),
      .set_addr (PC_WIDTH'(cmd.cmdData)),
      .pc       (pc),
      .bp_match (bp_term)
   );

   // Sticky breakpoint flag: cleared by resume commands, set when a breakpoint stops execution.
   always_comb begin
      bp_hit_d = bp_hit_q;
      if (cmd_run || cmd_step) begin
         bp_hit_d = 1'b0;
      end
      if (active && stop_now && bp_term) begin
         bp_hit_d = 1'b1;
      end
   end

   // Breakpoint flag register.
   always_ff @(posedge clock) begin
      if (!isResetN) begin
         bp_hit_q <= 1'b0;
      end else begin
         bp_hit_q <= bp_hit_d;
      end
   end

   assign bpHit = bp_hit_q;
`else
   logic unused_pc;

   assign bp_term   = 1'b0;
   assign bpHit     = 1'b0;
   assign unused_pc = ^pc;
`endif

   // Next-state logic for the run state, reset counter, step counter and resume skip.
   always_comb begin
      state_d      = state_q;
      rst_cnt_d    = rst_cnt_q;
      steps_left_d = steps_left_q;
      skip_d       = skip_q;
      if (cpu_en) begin
         skip_d = 1'b0;
      end
      case (state_q)
         RS_RESET: begin
            if (rst_cnt_q == CNT_LAST) begin
               state_d   = RS_HALTED;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         RS_HALTED: begin
            if (cmd_run) begin
               state_d = RS_RUNNING;
               skip_d  = 1'b1;
            end else if (cmd_step) begin
               state_d      = RS_STEPPING;
               steps_left_d = (cmd.cmdData == 8'd0) ? 8'd1 : cmd.cmdData;
               skip_d       = 1'b1;
            end
         end
         RS_RUNNING: begin
            if (stop_now || cmd_halt) begin
               state_d = RS_HALTED;
            end
         end
         RS_STEPPING: begin
            if (cpu_en) begin
               steps_left_d = steps_left_q - 8'd1;
            end
            if (stop_now || cmd_halt) begin
               state_d = RS_HALTED;
            end else if (cmd_run) begin
               state_d = RS_RUNNING;
            end else if (cpu_en && (steps_left_q == 8'd1)) begin
               state_d = RS_HALTED;
            end
         end
         default: begin
            state_d = RS_RESET;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!isResetN) begin
         state_q      <= RS_RESET;
         rst_cnt_q    <= '0;
         steps_left_q <= 8'd0;
         skip_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         steps_left_q <= steps_left_d;
         skip_q       <= skip_d;
      end
   end

   assign cmd.cmdReady = (state_q != RS_RESET);
   assign cpuEnable    = cpu_en;
   assign cpuReset     = (state_q == RS_RESET);
   assign runState     = state_q;
   assign stepsLeft    = steps_left_q;

endmodule

// File: tb/tb_run_control.sv
// Directed testbench for run_control. A tiny CPU model advances pc on every
// committed instruction; opCode presents the HALT opcode at a chosen pc.
// Breakpoint scenarios follow RUN_CONTROL_BREAKPOINT_EN.
module tb_run_control;
   import run_control_pkg::*;

   logic       clock = 1'b0;
   logic       isResetN = 1'b0;
   logic [7:0] pc;
   logic [5:0] opCode;
   logic       cpuEnable;
   logic       cpuReset;
   logic [1:0] runState;
   logic [7:0] stepsLeft;
   logic       bpHit;

   logic       haltArm = 1'b0;
   logic [7:0] haltPc  = 8'h00;

   int checks   = 0;
   int failures = 0;

   run_control_if cmd();

   run_control dut (
      .clock     (clock),
      .isResetN  (isResetN),
      .cmd       (cmd),
      .pc        (pc),
      .opCode    (opCode),
      .cpuEnable (cpuEnable),
      .cpuReset  (cpuReset),
      .runState  (runState),
      .stepsLeft (stepsLeft),
      .bpHit     (bpHit)
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // CPU model: pc returns to 0 in reset and advances on each committed instruction.
   always @(posedge clock) begin
      if (cpuReset) begin
         pc <= 8'h00;
      end else if (cpuEnable) begin
         pc <= pc + 8'h01;
      end
   end

   assign opCode = (haltArm && (pc == haltPc)) ? 6'h3F : 6'h00;

   task automatic tick();
      @(negedge clock);
   endtask

   // Present one command for a single cycle, starting at a falling edge.
   task automatic applyStimulus(input logic [1:0] code, input logic [7:0] data);
      cmd.cmdValid = 1'b1;
      cmd.cmdCode  = code;
      cmd.cmdData  = data;
      tick();
      cmd.cmdValid = 1'b0;
      cmd.cmdCode  = 2'b00;
      cmd.cmdData  = 8'h00;
   endtask

   task automatic doReset();
      isResetN = 1'b0;
      tick();
      isResetN = 1'b1;
      for (int i = 0; i < 20 && runState !== RS_HALTED; i++) tick();
      checks++;
      if (runState !== RS_HALTED) begin
         failures++;
         $display("[TB] FAIL doReset_timeout: runState=%0d expected=%0d", runState, RS_HALTED);
      end
   endtask

   task automatic test_reset();
      int highCycles;
      cmd.cmdValid = 1'b0;
      cmd.cmdCode  = 2'b00;
      cmd.cmdData  = 8'h00;
      isResetN     = 1'b0;
      tick();
      tick();
      checks++; if (runState !== RS_RESET) begin failures++; $display("[TB] FAIL reset_state: got %0d expected %0d", runState, RS_RESET); end
      checks++; if (cpuReset !== 1'b1) begin failures++; $display("[TB] FAIL reset_cpuReset: got %b expected 1", cpuReset); end
      checks++; if (cmd.cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmdReady: got %b expected 0", cmd.cmdReady); end
      checks++; if (cpuEnable !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpuEnable: got %b expected 0", cpuEnable); end
      checks++; if (stepsLeft !== 8'd0) begin failures++; $display("[TB] FAIL reset_stepsLeft: got %0d expected 0", stepsLeft); end
      checks++; if (bpHit !== 1'b0) begin failures++; $display("[TB] FAIL reset_bpHit: got %b expected 0", bpHit); end
      isResetN   = 1'b1;
      highCycles = 0;
      for (int i = 0; i < 20 && cpuReset === 1'b1; i++) begin
         highCycles++;
         tick();
      end
      checks++; if (highCycles != 4) begin failures++; $display("[TB] FAIL reset_hold_cycles: got %0d expected 4", highCycles); end
      checks++; if (runState !== RS_HALTED) begin failures++; $display("[TB] FAIL reset_exit_state: got %0d expected %0d", runState, RS_HALTED); end
      checks++; if (cmd.cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_exit_cmdReady: got %b expected 1", cmd.cmdReady); end
      checks++; if (cpuEnable !== 1'b0) begin failures++; $display("[TB] FAIL reset_exit_cpuEnable: got %b expected 0", cpuEnable); end
   endtask

   task automatic test_stepping();
      int en;
      applyStimulus(CMD_STEP, 8'd3);
      en = 0;
      for (int i = 0; i < 10 && runState !== RS_HALTED; i++) begin
         if (cpuEnable === 1'b1) begin
            checks++;
            if (stepsLeft !== 8'(3 - en)) begin failures++; $display("[TB] FAIL step3_stepsLeft: got %0d expected %0d", stepsLeft, 3 - en); end
            en++;
         end
         tick();
      end
      checks++; if (en != 3) begin failures++; $display("[TB] FAIL step3_enables: got %0d expected 3", en); end
      checks++; if (runState !== RS_HALTED) begin failures++; $display("[TB] FAIL step3_end_state: got %0d expected %0d", runState, RS_HALTED); end
      checks++; if (stepsLeft !== 8'd0) begin failures++; $display("[TB] FAIL step3_end_stepsLeft: got %0d expected 0", stepsLeft); end
      checks++; if (pc !== 8'h03) begin failures++; $display("[TB] FAIL step3_pc: got %0h expected 3", pc); end

      applyStimulus(CMD_STEP, 8'd0);
      checks++; if (stepsLeft !== 8'd1) begin failures++; $display("[TB] FAIL step0_load: got %0d expected 1", stepsLeft); end
      en = 0;
      for (int i = 0; i < 10 && runState !== RS_HALTED; i++) begin
         if (cpuEnable === 1'b1) en++;
         tick();
      end
      checks++; if (en != 1) begin failures++; $display("[TB] FAIL step0_enables: got %0d expected 1", en); end
      checks++; if (pc !== 8'h04) begin failures++; $display("[TB] FAIL step0_pc: got %0h expected 4", pc); end
   endtask

`ifdef RUN_CONTROL_BREAKPOINT_EN
   task automatic test_breakpoint();
      int         enCount;
      logic [7:0] stopPc;
      doReset();
      applyStimulus(CMD_SETBP, 8'h05);
      applyStimulus(CMD_RUN, 8'h00);
      enCount = 0;
      stopPc  = 8'hFF;
      for (int i = 0; i < 30 && runState === RS_RUNNING; i++) begin
         if (cpuEnable === 1'b1) enCount++;
         else stopPc = pc;
         tick();
      end
      checks++; if (enCount != 5) begin failures++; $display("[TB] FAIL bp_enables: got %0d expected 5", enCount); end
      checks++; if (stopPc !== 8'h05) begin failures++; $display("[TB] FAIL bp_stop_pc: got %0h expected 5", stopPc); end
      checks++; if (runState !== RS_HALTED) begin failures++; $display("[TB] FAIL bp_state: got %0d expected %0d", runState, RS_HALTED); end
      checks++; if (bpHit !== 1'b1) begin failures++; $display("[TB] FAIL bp_hit_set: got %b expected 1", bpHit); end
      applyStimulus(CMD_RUN, 8'h00);
      checks++; if (runState !== RS_RUNNING) begin failures++; $display("[TB] FAIL bp_resume_state: got %0d expected %0d", runState, RS_RUNNING); end
      checks++; if (pc !== 8'h05 || cpuEnable !== 1'b1) begin failures++; $display("[TB] FAIL bp_resume_exec: got pc=%0h en=%b expected pc=5 en=1", pc, cpuEnable); end
      checks++; if (bpHit !== 1'b0) begin failures++; $display("[TB] FAIL bp_hit_clear: got %b expected 0", bpHit); end
      tick();
      checks++; if (pc !== 8'h06) begin failures++; $display("[TB] FAIL bp_resume_pc: got %0h expected 6", pc); end
      applyStimulus(CMD_HALT, 8'h00);
      checks++; if (runState !== RS_HALTED || pc !== 8'h07) begin failures++; $display("[TB] FAIL bp_halt_cmd: got state=%0d pc=%0h expected state=%0d pc=7", runState, pc, RS_HALTED); end
   endtask

   task automatic test_halt_cmd_with_bp();
      doReset();
      applyStimulus(CMD_SETBP, 8'h02);
      applyStimulus(CMD_RUN, 8'h00);
      tick();
      tick();
      checks++; if (pc !== 8'h02 || cpuEnable !== 1'b0) begin failures++; $display("[TB] FAIL haltbp_match: got pc=%0h en=%b expected pc=2 en=0", pc, cpuEnable); end
      applyStimulus(CMD_HALT, 8'h00);
      checks++; if (runState !== RS_HALTED) begin failures++; $display("[TB] FAIL haltbp_state: got %0d expected %0d", runState, RS_HALTED); end
      checks++; if (bpHit !== 1'b1) begin failures++; $display("[TB] FAIL haltbp_bpHit: got %b expected 1", bpHit); end
      applyStimulus(CMD_HALT, 8'h00);
      checks++; if (runState !== RS_HALTED || bpHit !== 1'b1) begin failures++; $display("[TB] FAIL haltbp_ignored_halt: got state=%0d bpHit=%b expected state=%0d bpHit=1", runState, bpHit, RS_HALTED); end
   endtask
`else
   task automatic test_no_breakpoint();
      doReset();
      applyStimulus(CMD_SETBP, 8'h02);
      checks++; if (runState !== RS_HALTED) begin failures++; $display("[TB] FAIL nobp_setbp_state: got %0d expected %0d", runState, RS_HALTED); end
      applyStimulus(CMD_RUN, 8'h00);
      for (int i = 0; i < 6; i++) tick();
      checks++; if (runState !== RS_RUNNING) begin failures++; $display("[TB] FAIL nobp_state: got %0d expected %0d", runState, RS_RUNNING); end
      checks++; if (pc !== 8'h06) begin failures++; $display("[TB] FAIL nobp_pc: got %0h expected 6", pc); end
      checks++; if (bpHit !== 1'b0) begin failures++; $display("[TB] FAIL nobp_bpHit: got %b expected 0", bpHit); end
      applyStimulus(CMD_HALT, 8'h00);
   endtask
`endif

   task automatic test_halt_opcode();
      int         enCount;
      logic [7:0] stopPc;
      doReset();
      haltPc  = 8'h03;
      haltArm = 1'b1;
      applyStimulus(CMD_RUN, 8'h00);
      enCount = 0;
      stopPc  = 8'hFF;
      for (int i = 0; i < 30 && runState === RS_RUNNING; i++) begin
         if (cpuEnable === 1'b1) enCount++;
         else stopPc = pc;
         tick();
      end
      checks++; if (enCount != 3) begin failures++; $display("[TB] FAIL hop_enables: got %0d expected 3", enCount); end
      checks++; if (stopPc !== 8'h03) begin failures++; $display("[TB] FAIL hop_stop_pc: got %0h expected 3", stopPc); end
      checks++; if (runState !== RS_HALTED) begin failures++; $display("[TB] FAIL hop_state: got %0d expected %0d", runState, RS_HALTED); end
      checks++; if (bpHit !== 1'b0) begin failures++; $display("[TB] FAIL hop_bpHit: got %b expected 0", bpHit); end
      applyStimulus(CMD_RUN, 8'h00);
      checks++; if (pc !== 8'h03 || cpuEnable !== 1'b1) begin failures++; $display("[TB] FAIL hop_resume_exec: got pc=%0h en=%b expected pc=3 en=1", pc, cpuEnable); end
      tick();
      checks++; if (pc !== 8'h04) begin failures++; $display("[TB] FAIL hop_resume_pc: got %0h expected 4", pc); end
      haltArm = 1'b0;
      applyStimulus(CMD_HALT, 8'h00);
   endtask

   task automatic test_reset_mid_step();
      doReset();
      applyStimulus(CMD_SETBP, 8'h08);
      applyStimulus(CMD_STEP, 8'd10);
      for (int i = 0; i < 4; i++) tick();
      checks++; if (stepsLeft !== 8'd6 || runState !== RS_STEPPING) begin failures++; $display("[TB] FAIL midstep_before: got steps=%0d state=%0d expected steps=6 state=%0d", stepsLeft, runState, RS_STEPPING); end
      isResetN = 1'b0;
      tick();
      checks++; if (runState !== RS_RESET) begin failures++; $display("[TB] FAIL midstep_state: got %0d expected %0d", runState, RS_RESET); end
      checks++; if (stepsLeft !== 8'd0) begin failures++; $display("[TB] FAIL midstep_stepsLeft: got %0d expected 0", stepsLeft); end
      checks++; if (cpuReset !== 1'b1 || cpuEnable !== 1'b0 || cmd.cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL midstep_outputs: got rst=%b en=%b rdy=%b expected 1 0 0", cpuReset, cpuEnable, cmd.cmdReady); end
      isResetN = 1'b1;
      for (int i = 0; i < 20 && runState !== RS_HALTED; i++) tick();
      checks++; if (runState !== RS_HALTED) begin failures++; $display("[TB] FAIL midstep_release: got %0d expected %0d", runState, RS_HALTED); end
      applyStimulus(CMD_RUN, 8'h00);
      for (int i = 0; i < 12; i++) tick();
      checks++; if (runState !== RS_RUNNING || pc !== 8'h0C) begin failures++; $display("[TB] FAIL midstep_bp_cleared: got state=%0d pc=%0h expected state=%0d pc=c", runState, pc, RS_RUNNING); end
      checks++; if (bpHit !== 1'b0) begin failures++; $display("[TB] FAIL midstep_bpHit: got %b expected 0", bpHit); end
      applyStimulus(CMD_HALT, 8'h00);
   endtask

   task automatic test_back_to_back();
      doReset();
      applyStimulus(CMD_STEP, 8'd5);
      applyStimulus(CMD_RUN, 8'h00);
      checks++; if (runState !== RS_RUNNING || pc !== 8'h01) begin failures++; $display("[TB] FAIL b2b_step_to_run: got state=%0d pc=%0h expected state=%0d pc=1", runState, pc, RS_RUNNING); end
      applyStimulus(CMD_STEP, 8'd2);
      checks++; if (runState !== RS_RUNNING || pc !== 8'h02) begin failures++; $display("[TB] FAIL b2b_step_ignored: got state=%0d pc=%0h expected state=%0d pc=2", runState, pc, RS_RUNNING); end
      applyStimulus(CMD_HALT, 8'h00);
      checks++; if (runState !== RS_HALTED || pc !== 8'h03) begin failures++; $display("[TB] FAIL b2b_halt: got state=%0d pc=%0h expected state=%0d pc=3", runState, pc, RS_HALTED); end
      applyStimulus(CMD_HALT, 8'h00);
      checks++; if (runState !== RS_HALTED || cpuEnable !== 1'b0) begin failures++; $display("[TB] FAIL b2b_halt_ignored: got state=%0d en=%b expected state=%0d en=0", runState, cpuEnable, RS_HALTED); end
   endtask

   initial begin
      test_reset();
      test_stepping();
`ifdef RUN_CONTROL_BREAKPOINT_EN
      test_breakpoint();
      test_halt_cmd_with_bp();
`else
      test_no_breakpoint();
`endif
      test_halt_opcode();
      test_reset_mid_step();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 SHALL have parameters PC_WIDTH, default 8, width of pc and breakpoint address.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 6, width of opCode.
REQ-003 SHALL have parameter RESET_CYCLES, default 4, cycles cpuReset is held after reset release.
REQ-004 SHALL have parameter HALT_OPCODE, default all-ones, opcode that stops execution.
REQ-005 Ports SHALL be:
- clock  in  1  single clock; all logic on rising edge.
- isResetN  in  1  reset; synchronous, active-low.
- cmdValid  in  1  host command present.
- cmdReady  out  1  command accepted when cmdValid & cmdReady.
- cmdCode  in  2  00 HALT, 01 RUN, 10 STEP, 11 SETBP.
- cmdData  in  8  STEP count, or SETBP address (low PC_WIDTH bits).
- pc  in  PC_WIDTH  address of the instruction currently presented by the CPU.
- opCode  in  OPCODE_WIDTH  decoded opcode of that instruction.
- cpuEnable  out  1  CPU commits the current instruction (PC advance, register write) this cycle.
- cpuReset  out  1  drives the CPU reset input.
- runState  out  2  00 RESET, 01 HALTED, 10 RUNNING, 11 STEPPING.
- stepsLeft  out  8  remaining STEP instructions.
- bpHit  out  1  sticky; set when a breakpoint stopped execution.

Function
REQ-006 States SHALL be RESET, HALTED, RUNNING and STEPPING; RESET counts RESET_CYCLES cycles with cpuReset=1, then moves to HALTED.
REQ-007 cmdReady SHALL be 1 in every state except RESET; an accepted command takes effect in the next state.
REQ-008 RUN: HALTED or STEPPING -> RUNNING; ignored in RUNNING.
REQ-009 HALT: RUNNING or STEPPING -> HALTED; ignored in HALTED.
REQ-010 STEP N: HALTED -> STEPPING with stepsLeft=N, where N=0 is loaded as 1; ignored in RUNNING and STEPPING.
REQ-011 SETBP: loads the breakpoint address and sets bpValid in any non-RESET state; it does not change state.
REQ-012 stopNow SHALL be ((bpValid & pc==bpAddr) | opCode==HALT_OPCODE) & !skip.
REQ-013 cpuEnable SHALL be combinational: (RUNNING | STEPPING) & !stopNow.
REQ-014 stopNow in RUNNING or STEPPING SHALL move the block to HALTED next cycle; bpHit SHALL be set if the breakpoint term matched.
REQ-015 skip SHALL be set on entry to RUNNING or STEPPING from HALTED, so that resume executes the instruction at the stop address; it is cleared after the first cpuEnable=1 cycle.
REQ-016 In STEPPING, each cpuEnable=1 cycle SHALL decrement stepsLeft; when stepsLeft==1 and cpuEnable=1, the next state is HALTED with stepsLeft=0.
REQ-017 If a HALT command and stopNow occur in the same cycle, the next state SHALL be HALTED and bpHit SHALL be updated per REQ-014.
REQ-018 Any accepted RUN or STEP command SHALL clear bpHit.
REQ-019 In RESET and HALTED, cpuEnable SHALL be 0.

Reset
REQ-020 isResetN=0 at a clock edge SHALL, from any state including mid-STEP, force RESET with the following values:
- RESET counter = 0
- cpuReset = 1
- stepsLeft = 0
- bpHit = 0
- bpValid = 0
- bpAddr = 0
- skip = 0
REQ-021 cpuEnable SHALL be 0 and cmdReady SHALL be 0 while in RESET.

Configuration
REQ-022 With RUN_CONTROL_BREAKPOINT_EN defined, breakpoint logic SHALL be as specified above.
REQ-023 Without RUN_CONTROL_BREAKPOINT_EN, no breakpoint registers SHALL be built: SETBP is accepted and ignored, the breakpoint term is 0, and bpHit is constant 0.

Structure
REQ-024 The run-state encoding, cmdCode encoding and HALT_OPCODE default SHALL live in the shared global parameters package used by the CPU.
REQ-025 The breakpoint compare and register SHALL be one sub-module, breakpoint_unit, instantiated only when RUN_CONTROL_BREAKPOINT_EN is defined.

Verification
REQ-026 Reset behaviour: release isResetN -> cpuReset=1 for exactly 4 cycles, then runState=HALTED, cmdReady=1, cpuEnable=0.
REQ-027 Stepping: STEP 3 from HALTED, pc 0x00..0x02 -> exactly 3 cpuEnable cycles, stepsLeft 3->2->1->0, then HALTED; STEP 0 -> exactly 1 enabled cycle.
REQ-028 Breakpoint hit: SETBP 0x05, then RUN, pc increments from 0 -> enabled for pc 0x00..0x04, cpuEnable=0 at pc 0x05, HALTED, bpHit=1. A second RUN -> pc 0x05 executes, bpHit clears.
REQ-029 Halt opcode: opCode=HALT_OPCODE while RUNNING -> cpuEnable=0 that cycle, HALTED next cycle, bpHit=0; HALT command in the same cycle as a breakpoint match -> HALTED, bpHit=1.
REQ-030 Reset mid-step: drop isResetN during STEP 10 with stepsLeft=6 -> RESET, stepsLeft=0, bpValid cleared (breakpoint at the old address no longer stops execution after RUN).
REQ-031 Configuration: build without RUN_CONTROL_BREAKPOINT_EN, SETBP 0x02, RUN -> no stop at pc 0x02, bpHit stays 0.
